call_return_ctrl: RTL and testbench

Return-address controller between the processor fetch stage and the team's `stack` block. It turns CALL/RET requests into single-cycle push/pop transactions on the stack. It computes and stores return addresses, absorbs the stack's one-cycle pop data latency, and redirects fetch via next_pc/pc_load. Stall and fault indication go back to the pipeline.

---
 rtl/callctrl_pkg.sv | 16 +
 rtl/call_return_ctrl.sv | 116 +++++++++++
 tb/tb_call_return_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/callctrl_pkg.sv
// Shared types and default constants for the call/return controller.
// The trap-on-fault option is enabled by defining CALLCTRL_TRAP_EN.
package callctrl_pkg;

    localparam int CALLCTRL_ADDR_WIDTH = 32;
    localparam int CALLCTRL_RET_OFFSET = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PUSH  = 3'd1,
        POP   = 3'd2,
        WAIT  = 3'd3,
        FAULT = 3'd4
    } callctrl_state_e;

endpackage

// File: rtl/call_return_ctrl.sv
// Return-address controller: turns CALL/RET into stack push/pop and redirects fetch.
// Optional CALLCTRL_TRAP_EN: a fault loads TRAP_VECTOR into fetch and resumes instead of locking up.
//
//   state | meaning
//   IDLE  | sampling call/ret; the only state where requests are accepted
//   PUSH  | push strobe with the return address; call redirect pulse
//   POP   | pop strobe; stack read data arrives next cycle
//   WAIT  | capture stack read data as the redirect address
//   FAULT | overflow/underflow; terminal unless the trap option is built in
module call_return_ctrl
    import callctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = CALLCTRL_ADDR_WIDTH,
    parameter int RET_OFFSET = CALLCTRL_RET_OFFSET
`ifdef CALLCTRL_TRAP_EN
    ,
    parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = ADDR_WIDTH'(32'h0000_0100)
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  call,
    input  logic                  ret,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] target,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [ADDR_WIDTH-1:0] stk_data_in,
    input  logic [ADDR_WIDTH-1:0] stk_data_out,
    input  logic                  stk_full,
    input  logic                  stk_empty,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  pc_load,
    output logic                  stall,
    output logic                  fault
);

    callctrl_state_e       state_q, state_d;
    logic [ADDR_WIDTH-1:0] stk_data_in_q, stk_data_in_d;
    logic [ADDR_WIDTH-1:0] next_pc_q, next_pc_d;
    logic                  pc_load_q, pc_load_d;
    logic                  fault_q, fault_d;
    logic                  take_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            stk_data_in_q <= '0;
            next_pc_q     <= '0;
            pc_load_q     <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            stk_data_in_q <= stk_data_in_d;
            next_pc_q     <= next_pc_d;
            pc_load_q     <= pc_load_d;
            fault_q       <= fault_d;
        end
    end

    // call wins over ret, so ret only faults on underflow when call is low
    assign take_fault = (state_q == IDLE) &&
                        ((call && stk_full) || (!call && ret && stk_empty));

    always_comb begin
        state_d       = state_q;
        stk_data_in_d = stk_data_in_q;
        next_pc_d     = next_pc_q;
        pc_load_d     = 1'b0;
        fault_d       = fault_q;

        unique case (state_q)
            IDLE: begin
                if (take_fault) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
`ifdef CALLCTRL_TRAP_EN
                    next_pc_d = TRAP_VECTOR;
                    pc_load_d = 1'b1;
`endif
                end else if (call) begin
                    state_d       = PUSH;
                    stk_data_in_d = pc + ADDR_WIDTH'(RET_OFFSET);
                    next_pc_d     = target;
                    pc_load_d     = 1'b1;
                end else if (ret) begin
                    state_d = POP;
                end
            end
            PUSH: state_d = IDLE;
            POP:  state_d = WAIT;
            WAIT: begin
                next_pc_d = stk_data_out;
                pc_load_d = 1'b1;
                state_d   = IDLE;
            end
            FAULT: begin
`ifdef CALLCTRL_TRAP_EN
                state_d = IDLE;
`else
                state_d = FAULT;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall       = (state_q != IDLE);
    assign stk_push    = (state_q == PUSH);
    assign stk_pop     = (state_q == POP);
    assign stk_data_in = stk_data_in_q;
    assign next_pc     = next_pc_q;
    assign pc_load     = pc_load_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_call_return_ctrl.sv
// Self-checking bench for call_return_ctrl with a behavioural stack and redirect/push scoreboards.
module tb_call_return_ctrl;
    import callctrl_pkg::*;

`ifdef CALLCTRL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, call, ret;
    logic [31:0] pc, target, stk_data_in, stk_data_out, next_pc;
    logic        stk_push, stk_pop, stk_full, stk_empty, pc_load, stall, fault;
    logic        force_full, force_empty;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_redir[$];
    logic [31:0] exp_push[$];
    logic [31:0] mdl[$];
    int          mdl_depth;

    always #5 clk = ~clk;

    call_return_ctrl dut (
        .clk(clk), .reset(reset), .call(call), .ret(ret), .pc(pc), .target(target),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
        .stk_data_out(stk_data_out), .stk_full(stk_full), .stk_empty(stk_empty),
        .next_pc(next_pc), .pc_load(pc_load), .stall(stall), .fault(fault)
    );

    // behavioural stack: read data valid the cycle after a pop
    always @(posedge clk) begin
        if (reset) begin
            mdl.delete();
            stk_data_out <= '0;
            mdl_depth    <= 0;
        end else begin
            if (stk_push) mdl.push_back(stk_data_in);
            if (stk_pop && mdl.size() > 0) stk_data_out <= mdl.pop_back();
            mdl_depth <= mdl.size();
        end
    end

    assign stk_full  = force_full;
    assign stk_empty = force_empty || (mdl_depth == 0);

    always @(negedge clk) begin
        if (!reset && pc_load) begin
            checks++;
            if (exp_redir.size() == 0) begin
                errors++;
                $display("FAIL redirect_unexpected got next_pc=%0h exp none", next_pc);
            end else begin
                logic [31:0] e;
                e = exp_redir.pop_front();
                if (next_pc !== e) begin
                    errors++;
                    $display("FAIL redirect_addr got %0h exp %0h", next_pc, e);
                end
            end
        end
        if (!reset && stk_push) begin
            checks++;
            if (exp_push.size() == 0) begin
                errors++;
                $display("FAIL push_unexpected got data=%0h exp none", stk_data_in);
            end else begin
                logic [31:0] e;
                e = exp_push.pop_front();
                if (stk_data_in !== e) begin
                    errors++;
                    $display("FAIL push_data got %0h exp %0h", stk_data_in, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; call = 1'b0; ret = 1'b0; pc = '0; target = '0;
        force_full = 1'b0; force_empty = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_redir.delete();
        exp_push.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({stall, pc_load, stk_push, stk_pop, fault} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl got %05b exp 00000", {stall, pc_load, stk_push, stk_pop, fault});
        end
        checks++;
        if (next_pc !== 32'h0 || stk_data_in !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got next_pc=%0h data_in=%0h exp 0 0", next_pc, stk_data_in);
        end
    endtask

    task automatic test_call();
        call = 1'b1; pc = 32'h40; target = 32'h200;
        exp_push.push_back(32'h44); exp_redir.push_back(32'h200);
        tick();
        call = 1'b0;
        checks++;
        if ({stk_push, pc_load, stall, stk_pop} !== 4'b1110) begin
            errors++;
            $display("FAIL call_t1 got push/load/stall/pop=%04b exp 1110", {stk_push, pc_load, stall, stk_pop});
        end
        checks++;
        if (stk_data_in !== 32'h44 || next_pc !== 32'h200) begin
            errors++;
            $display("FAIL call_data got data_in=%0h next_pc=%0h exp 44 200", stk_data_in, next_pc);
        end
        tick();
        checks++;
        if ({stk_push, pc_load, stall} !== 3'b000) begin
            errors++;
            $display("FAIL call_t2 got push/load/stall=%03b exp 000", {stk_push, pc_load, stall});
        end
    endtask

    task automatic test_ret();
        ret = 1'b1;
        exp_redir.push_back(32'h44);
        tick();
        ret = 1'b0;
        call = 1'b1; pc = 32'h999; target = 32'haaa;  // must be ignored while stalled
        checks++;
        if ({stk_pop, stall, pc_load, stk_push} !== 4'b1100) begin
            errors++;
            $display("FAIL ret_t1 got pop/stall/load/push=%04b exp 1100", {stk_pop, stall, pc_load, stk_push});
        end
        tick();
        checks++;
        if ({stk_pop, stall, pc_load, stk_push} !== 4'b0100) begin
            errors++;
            $display("FAIL ret_t2 got pop/stall/load/push=%04b exp 0100", {stk_pop, stall, pc_load, stk_push});
        end
        tick();
        call = 1'b0;
        checks++;
        if (pc_load !== 1'b1 || next_pc !== 32'h44 || stall !== 1'b0 || stk_push !== 1'b0) begin
            errors++;
            $display("FAIL ret_t3 got load=%0b next_pc=%0h stall=%0b push=%0b exp 1 44 0 0",
                     pc_load, next_pc, stall, stk_push);
        end
        tick();
        checks++;
        if (pc_load !== 1'b0 || next_pc !== 32'h44 || stk_push !== 1'b0) begin
            errors++;
            $display("FAIL ret_hold got load=%0b next_pc=%0h push=%0b exp 0 44 0", pc_load, next_pc, stk_push);
        end
    endtask

    task automatic test_priority();
        call = 1'b1; ret = 1'b1; pc = 32'h10; target = 32'h80;
        exp_push.push_back(32'h14); exp_redir.push_back(32'h80);
        tick();
        call = 1'b0; ret = 1'b0;
        checks++;
        if (stk_push !== 1'b1 || stk_pop !== 1'b0 || stk_data_in !== 32'h14 || next_pc !== 32'h80) begin
            errors++;
            $display("FAIL priority got push=%0b pop=%0b data_in=%0h next_pc=%0h exp 1 0 14 80",
                     stk_push, stk_pop, stk_data_in, next_pc);
        end
        tick();
        checks++;
        if (stk_pop !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL priority_nopop got pop=%0b stall=%0b exp 0 0", stk_pop, stall);
        end
    endtask

    task automatic test_back_to_back();
        call = 1'b1; pc = 32'h100; target = 32'h300;
        exp_push.push_back(32'h104); exp_redir.push_back(32'h300);
        tick();
        pc = 32'h200; target = 32'h400;
        exp_push.push_back(32'h204); exp_redir.push_back(32'h400);
        tick();
        checks++;
        if (stall !== 1'b0 || stk_push !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got stall=%0b push=%0b exp 0 0", stall, stk_push);
        end
        tick();
        call = 1'b0;
        checks++;
        if (stk_push !== 1'b1 || stk_data_in !== 32'h204) begin
            errors++;
            $display("FAIL b2b_second got push=%0b data_in=%0h exp 1 204", stk_push, stk_data_in);
        end
        tick();
        ret = 1'b1;
        exp_redir.push_back(32'h204); exp_redir.push_back(32'h104);
        repeat (4) tick();
        ret = 1'b0;
        checks++;
        if (stk_pop !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_pop got pop=%0b exp 1", stk_pop);
        end
        repeat (2) tick();
        checks++;
        if (pc_load !== 1'b1 || next_pc !== 32'h104) begin
            errors++;
            $display("FAIL b2b_ret2 got load=%0b next_pc=%0h exp 1 104", pc_load, next_pc);
        end
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        force_full = 1'b1;
        call = 1'b1; pc = 32'h50; target = 32'h60;
        if (TRAP) exp_redir.push_back(32'h100);
        tick();
        checks++;
        if (stk_push !== 1'b0 || fault !== 1'b1 || stall !== 1'b1) begin
            errors++;
            $display("FAIL overflow got push=%0b fault=%0b stall=%0b exp 0 1 1", stk_push, fault, stall);
        end
        checks++;
        if (pc_load !== TRAP || (TRAP && next_pc !== 32'h100)) begin
            errors++;
            $display("FAIL overflow_trap got load=%0b next_pc=%0h exp %0b 100", pc_load, next_pc, TRAP);
        end
        call = 1'b0; force_full = 1'b0;
        repeat (3) tick();
        checks++;
        if (stall !== !TRAP || fault !== 1'b1 || stk_push !== 1'b0) begin
            errors++;
            $display("FAIL overflow_after got stall=%0b fault=%0b push=%0b exp %0b 1 0",
                     stall, fault, stk_push, !TRAP);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        ret = 1'b1;
        if (TRAP) exp_redir.push_back(32'h100);
        tick();
        ret = 1'b0;
        checks++;
        if (stk_pop !== 1'b0 || fault !== 1'b1 || stall !== 1'b1) begin
            errors++;
            $display("FAIL underflow got pop=%0b fault=%0b stall=%0b exp 0 1 1", stk_pop, fault, stall);
        end
        call = 1'b1; pc = 32'h30; target = 32'h70;
        if (TRAP) begin
            exp_push.push_back(32'h34); exp_redir.push_back(32'h70);
        end
        tick();
        checks++;
        if (stall !== !TRAP) begin
            errors++;
            $display("FAIL underflow_resume got stall=%0b exp %0b", stall, !TRAP);
        end
        tick();
        call = 1'b0;
        checks++;
        if (stk_push !== TRAP || fault !== 1'b1) begin
            errors++;
            $display("FAIL underflow_call got push=%0b fault=%0b exp %0b 1", stk_push, fault, TRAP);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        call = 1'b1; pc = 32'h40; target = 32'h200;
        exp_push.push_back(32'h44); exp_redir.push_back(32'h200);
        tick();
        call = 1'b0;
        tick();
        ret = 1'b1;
        exp_redir.push_back(32'h44);
        tick();
        ret = 1'b0;
        tick();
        checks++;
        if (stall !== 1'b1 || stk_pop !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait got stall=%0b pop=%0b exp 1 0", stall, stk_pop);
        end
        reset = 1'b1;
        exp_redir.delete();
        tick();
        reset = 1'b0;
        checks++;
        if ({pc_load, stk_pop, stk_push, fault, stall} !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset got load/pop/push/fault/stall=%05b exp 00000",
                     {pc_load, stk_pop, stk_push, fault, stall});
        end
        call = 1'b1; pc = 32'h0; target = 32'h8;
        exp_push.push_back(32'h4); exp_redir.push_back(32'h8);
        tick();
        call = 1'b0;
        checks++;
        if (stk_push !== 1'b1 || stk_data_in !== 32'h4 || next_pc !== 32'h8) begin
            errors++;
            $display("FAIL mid_call got push=%0b data_in=%0h next_pc=%0h exp 1 4 8", stk_push, stk_data_in, next_pc);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_call();
        test_ret();
        test_priority();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_reset_mid();
        checks++;
        if (exp_redir.size() != 0 || exp_push.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got redir=%0d push=%0d pending exp 0 0", exp_redir.size(), exp_push.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
